// File: rtl/instruction_encoder_pkg.sv
// ============================================================================
// Module : instruction_encoder_pkg
// Brief  : RV32I major opcodes and the buffered-entry type for the encoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_encoder_pkg;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_i_type = 7'b0010011;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_s_type = 7'b0100011;
    localparam logic [6:0] c_op_r_type = 7'b0110011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_b_type = 7'b1100011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_j_type = 7'b1101111;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } entry_t;

    // True when v[31:msb] are all equal, i.e. v is representable as a
    // sign-extended (msb+1)-bit value.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
        logic [31:0] hi;
        hi = 32'($signed(v) >>> msb);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_encoder_if.sv
// ============================================================================
// Module : instruction_encoder_if
// Brief  : Field-input / instruction-output handshake bundle of the encoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        enc_err;
    logic [15:0] instr_count;

    modport master (
        output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, instr, enc_err, instr_count
    );

    modport slave (
        input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, instr, enc_err, instr_count
    );
endinterface

`default_nettype wire

// File: rtl/instruction_encoder_instr_pack.sv
// ============================================================================
// Module : instr_pack
// Brief  : Combinational RV32I field packer; optional immediate range check
//          enabled by macro IMM_RANGE_CHECK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_pack
    import instruction_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    logic w_is_shift;
    assign w_is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
        err   = 1'b0;
        case (opcode)
            c_op_i_type: begin
                if (w_is_shift) instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                else            instr = {imm[11:0], rs1, funct3, rd, opcode};
            end
            c_op_jalr, c_op_load: instr = {imm[11:0], rs1, funct3, rd, opcode};
            c_op_s_type: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            c_op_b_type: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            c_op_lui, c_op_auipc: instr = {imm[31:12], rd, opcode};
            c_op_j_type: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: ;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        case (opcode)
            c_op_i_type:                      err = !w_is_shift && !fits_signed(imm, 11);
            c_op_jalr, c_op_load, c_op_s_type: err = !fits_signed(imm, 11);
            c_op_b_type:                      err = !fits_signed(imm, 12) || imm[0];
            c_op_j_type:                      err = !fits_signed(imm, 20) || imm[0];
            c_op_lui, c_op_auipc:             err = |imm[11:0];
            c_op_r_type:                      err = 1'b0;
            default:                          err = 1'b1;
        endcase
`endif
    end

endmodule

`default_nettype wire

// File: rtl/instruction_encoder.sv
// ============================================================================
// Module : instruction_encoder
// Brief  : Registered RV32I instruction packer behind a two-entry skid buffer
//          with output handshake counter. Macro: IMM_RANGE_CHECK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_encoder
    import instruction_encoder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    instruction_encoder_if.slave  bus
);

    entry_t      w_packed;
    entry_t      r_main;
    entry_t      r_skid;
    logic        r_main_valid;
    logic        r_skid_valid;
    logic        r_in_ready;
    logic [15:0] r_count;
    logic        w_accept;
    logic        w_pop;
    logic        w_skid_valid_nxt;

    instr_pack u_pack (
        .opcode (bus.opcode),
        .rd     (bus.rd),
        .rs1    (bus.rs1),
        .rs2    (bus.rs2),
        .funct3 (bus.funct3),
        .funct7 (bus.funct7),
        .imm    (bus.imm),
        .instr  (w_packed.instr),
        .err    (w_packed.err)
    );

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_pop    = r_main_valid && bus.out_ready;

    // An accept can only happen with skid empty, so skid fills only when main
    // is occupied and not draining.
    assign w_skid_valid_nxt = (r_skid_valid && !w_pop) || (w_accept && r_main_valid && !w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_count      <= 16'd0;
        end else begin
            if (w_pop) r_count <= r_count + 16'd1;

            if (w_pop && r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
            end else if (w_pop || !r_main_valid) begin
                r_main_valid <= w_accept;
                if (w_accept) r_main <= w_packed;
            end else if (w_accept) begin
                r_skid <= w_packed;
            end

            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_main_valid;
    assign bus.instr       = r_main.instr;
    assign bus.enc_err     = r_main.err;
    assign bus.instr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instruction_encoder.sv
// ============================================================================
// Module : tb_instruction_encoder
// Brief  : Directed-vector bench for instruction_encoder (IMM_RANGE_CHECK_EN aware).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instruction_encoder;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_J     = 7'b1101111;
`ifdef IMM_RANGE_CHECK_EN
    localparam logic EXP_CHK = 1'b1;
`else
    localparam logic EXP_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_encoder_if bus ();

    instruction_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          exp_cnt = 0;
    logic [31:0] got_instr;
    logic        got_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference RV32I immediate extraction, used for round-trip checks.
    function automatic logic [31:0] imm_ext(input logic [31:0] i);
        case (i[6:0])
            OP_S:            return {{20{i[31]}}, i[31:25], i[11:7]};
            OP_B:            return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OP_J:            return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            OP_LUI, OP_AUIPC: return {i[31:12], 12'b0};
            default:         return {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        bus.opcode = op; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
        bus.funct3 = f3; bus.funct7 = f7; bus.imm = imm;
    endtask

    // One transfer with out_ready=1: returns the word seen one cycle after accept.
    task automatic xfer(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, output logic [31:0] instr, output logic err);
        int n = 0;
        bus.out_ready = 1'b1;
        while (!bus.in_ready && n < 16) begin
            @(posedge clk); #1; n++;
        end
        check_eq("in_ready_before_push", 32'(bus.in_ready), 32'd1);
        drive(op, rd, rs1, rs2, f3, f7, imm);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq("out_valid_latency", 32'(bus.out_valid), 32'd1);
        instr = bus.instr;
        err   = bus.enc_err;
        @(posedge clk); #1;
        exp_cnt++;
    endtask

    task automatic vec(input string tag, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm,
                       input logic [31:0] exp_instr, input logic exp_err);
        logic [31:0] gi;
        logic        ge;
        xfer(op, rd, rs1, rs2, f3, f7, imm, gi, ge);
        check_eq(tag, gi, exp_instr);
        check_eq({tag, "_err"}, 32'(ge), 32'(exp_err));
    endtask

    initial begin
        int          n;
        logic [31:0] r;
        logic [31:0] imm;
        logic [6:0]  op;

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_instr", bus.instr, 32'd0);
        check_eq("rst_enc_err", 32'(bus.enc_err), 32'd0);
        check_eq("rst_count", 32'(bus.instr_count), 32'd0);
        rst = 1'b0;

        vec("addi", OP_I, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd5, 32'h00510093, 1'b0);
        check_eq("count_after_addi", 32'(bus.instr_count), 32'd1);
        vec("sw", OP_S, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'd8, 32'h00512423, 1'b0);
        vec("beq_m4", OP_B, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
        vec("jal_800", OP_J, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00000800, 32'h001000EF, 1'b0);
        vec("lui", OP_LUI, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, 32'h123451B7, 1'b0);
        vec("add", OP_R, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'd0, 32'h002081B3, 1'b0);
        vec("sub", OP_R, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'd0, 32'h402081B3, 1'b0);
        vec("srai", OP_I, 5'd1, 5'd2, 5'd0, 3'b101, 7'h20, 32'd3, 32'h40315093, 1'b0);
        vec("jal_m2048", OP_J, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFF800, 32'h801FF06F, 1'b0);
        vec("addi_m2048", OP_I, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFF800, 32'h80000013, 1'b0);
        vec("addi_800", OP_I, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00000800, 32'h80000093, EXP_CHK);
        vec("beq_odd", OP_B, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3, 32'h00000163, EXP_CHK);
        vec("lui_lowbits", OP_LUI, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345678, 32'h123451B7, EXP_CHK);
        vec("unknown_op", 7'h7F, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'd0, 32'h002081FF, EXP_CHK);
        check_eq("count_after_vectors", 32'(bus.instr_count), 32'(exp_cnt));

        // Round trip through the reference immediate extraction.
        for (int i = 0; i < 10; i++) begin
            for (int t = 0; t < 5; t++) begin
                r = $urandom;
                case (t)
                    0: begin op = (i % 3 == 0) ? OP_I : (i % 3 == 1) ? OP_LOAD : OP_JALR;
                             imm = {{20{r[11]}}, r[11:0]}; end
                    1: begin op = OP_S; imm = {{20{r[11]}}, r[11:0]}; end
                    2: begin op = OP_B; imm = {{19{r[12]}}, r[12:1], 1'b0}; end
                    3: begin op = OP_J; imm = {{11{r[20]}}, r[20:1], 1'b0}; end
                    default: begin op = (i % 2 == 0) ? OP_LUI : OP_AUIPC; imm = {r[31:12], 12'b0}; end
                endcase
                xfer(op, 5'd7, 5'd9, 5'd11, 3'b000, 7'd0, imm, got_instr, got_err);
                check_eq("roundtrip_imm", imm_ext(got_instr), imm);
                check_eq("roundtrip_err", 32'(got_err), 32'd0);
            end
        end

        // Backpressure: A to main, B to skid, C held off.
        n = exp_cnt;
        bus.out_ready = 1'b0;
        drive(OP_I, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd5);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_ready_after_A", 32'(bus.in_ready), 32'd1);
        drive(OP_S, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'd8);
        @(posedge clk); #1;
        check_eq("bp_ready_after_B", 32'(bus.in_ready), 32'd0);
        check_eq("bp_hold_A", bus.instr, 32'h00510093);
        drive(OP_LUI, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000);
        @(posedge clk); #1;
        check_eq("bp_C_held", 32'(bus.in_ready), 32'd0);
        check_eq("bp_stable_A", bus.instr, 32'h00510093);
        check_eq("bp_valid_held", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_out_B", bus.instr, 32'h00512423);
        check_eq("bp_ready_rise", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq("bp_out_C", bus.instr, 32'h123451B7);
        @(posedge clk); #1;
        check_eq("bp_drained", 32'(bus.out_valid), 32'd0);
        check_eq("bp_count", 32'(bus.instr_count), 32'(n + 3));

        // Reset with both entries full.
        bus.out_ready = 1'b0;
        drive(OP_I, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd5);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        drive(OP_S, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'd8);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq("full_before_rst", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("midrst_count", 32'(bus.instr_count), 32'd0);
        check_eq("midrst_instr", bus.instr, 32'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_eq("no_stale_out", 32'(bus.out_valid), 32'd0);
        end
        vec("addi_after_rst", OP_I, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd5, 32'h00510093, 1'b0);
        check_eq("count_after_rst", 32'(bus.instr_count), 32'd1);

        // Full-rate stream up to counter wrap.
        drive(OP_I, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd5);
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.instr_count != 16'hFFFF && n < 65600) begin
            @(posedge clk); #1; n++;
        end
        bus.in_valid = 1'b0;
        check_eq("count_reach_ffff", 32'(bus.instr_count), 32'h0000FFFF);
        check_eq("stream_rate", 32'(n), 32'd65535);
        @(posedge clk); #1;
        check_eq("count_wrap", 32'(bus.instr_count), 32'd0);
        check_eq("wrap_drained", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
